// File: rtl/multicycle_control_fsm_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm_if
// Control bundle between the multicycle RV32I main FSM and its datapath.
//   slave  modport : FSM side (consumes opcode/mem_ready, drives controls)
//   master modport : datapath side (drives opcode/mem_ready, consumes controls)
// Signals:
//   opcode[6:0]      instruction opcode from the instruction register
//   mem_ready        memory finished the current access this cycle
//   adr_src          memory address select (0=PC, 1=ALUOut)
//   alu_src_a[1:0]   ALU A mux select
//   alu_src_b[1:0]   ALU B mux select
//   result_src[1:0]  result mux select
//   alu_op[1:0]      ALU decoder operation class
//   ir_write, pc_update, branch, reg_write, mem_write  write strobes
//   instret          retired-instruction count
//   illegal_instr    sticky illegal-opcode flag
// -----------------------------------------------------------------------------
interface multicycle_control_fsm_if #(
  parameter int INSTRET_W = 32
);
  logic [6:0]           opcode;
  logic                 mem_ready;
  logic                 adr_src;
  logic [1:0]           alu_src_a;
  logic [1:0]           alu_src_b;
  logic [1:0]           result_src;
  logic [1:0]           alu_op;
  logic                 ir_write;
  logic                 pc_update;
  logic                 branch;
  logic                 reg_write;
  logic                 mem_write;
  logic [INSTRET_W-1:0] instret;
  logic                 illegal_instr;

  modport slave (
    input  opcode, mem_ready,
    output adr_src, alu_src_a, alu_src_b, result_src, alu_op,
           ir_write, pc_update, branch, reg_write, mem_write,
           instret, illegal_instr
  );

  modport master (
    output opcode, mem_ready,
    input  adr_src, alu_src_a, alu_src_b, result_src, alu_op,
           ir_write, pc_update, branch, reg_write, mem_write,
           instret, illegal_instr
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
// Main control FSM of the multicycle RV32I core. Sequences every instruction
// through fetch / decode / execute / memory / writeback, produces the datapath
// mux selects and write strobes, stalls on mem_ready and counts retirements.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous, active-high reset (state -> FETCH, counters cleared)
//   bus  - multicycle_control_fsm_if.slave control bundle
// Build option:
//   CTRL_ILLEGAL_TRAP_EN - when defined, an unknown opcode parks the FSM in a
//   TRAP state with illegal_instr=1 until reset; otherwise the unknown opcode
//   is skipped as an uncounted nop and illegal_instr is tied 0.
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int INSTRET_W         = 32,
  parameter bit RESET_STATE_FETCH = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  multicycle_control_fsm_if.slave   bus
);

  // Only a FETCH reset state is supported.
  if (RESET_STATE_FETCH != 1'b1) begin : g_bad_reset_state
    $error("RESET_STATE_FETCH must be 1");
  end

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    LUI      = 4'd8,
    AUIPC    = 4'd9,
    ALUWB    = 4'd10,
    BRANCH   = 4'd11,
    JALR     = 4'd12,
`ifdef CTRL_ILLEGAL_TRAP_EN
    JAL      = 4'd13,
    TRAP     = 4'd14
`else
    JAL      = 4'd13
`endif
  } state_t;

  state_t               state_q, state_d;
  logic                 adr_src_q, adr_src_d;
  logic [1:0]           alu_src_a_q, alu_src_a_d;
  logic [1:0]           alu_src_b_q, alu_src_b_d;
  logic [1:0]           result_src_q, result_src_d;
  logic [1:0]           alu_op_q, alu_op_d;
  logic                 jal_pc_q, jal_pc_d;
  logic                 branch_q, branch_d;
  logic                 reg_write_q, reg_write_d;
  logic                 mem_write_q, mem_write_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 retire;
  logic                 fetch_strobe;

  // Next-state logic. Encodings outside the enum fall back to FETCH.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (bus.mem_ready) state_d = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_R:              state_d = EXECR;
          OP_I:              state_d = EXECI;
          OP_BR:             state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          OP_JALR:           state_d = JALR;
          OP_LUI:            state_d = LUI;
          OP_AUIPC:          state_d = AUIPC;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:           state_d = TRAP;
`else
          default:           state_d = FETCH;
`endif
        endcase
      end
      MEMADR:   state_d = (bus.opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (bus.mem_ready) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (bus.mem_ready) state_d = FETCH;
      EXECR, EXECI, LUI, AUIPC: state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      JALR:     state_d = JAL;
      JAL:      state_d = ALUWB;
`ifdef CTRL_ILLEGAL_TRAP_EN
      TRAP:     state_d = TRAP;
`endif
      default:  state_d = FETCH;
    endcase
  end

  // Moore outputs decoded from the state being entered, so the output flops
  // carry exactly the values of the state register next cycle.
  always_comb begin
    adr_src_d    = 1'b0;
    alu_src_a_d  = 2'b00;
    alu_src_b_d  = 2'b00;
    result_src_d = 2'b00;
    alu_op_d     = 2'b00;
    jal_pc_d     = 1'b0;
    branch_d     = 1'b0;
    reg_write_d  = 1'b0;
    mem_write_d  = 1'b0;
    case (state_d)
      FETCH:    begin alu_src_b_d = 2'b10; result_src_d = 2'b10; end
      DECODE:   begin alu_src_a_d = 2'b01; alu_src_b_d = 2'b01; end
      MEMADR:   begin alu_src_a_d = 2'b10; alu_src_b_d = 2'b01; end
      MEMREAD:  adr_src_d = 1'b1;
      MEMWB:    begin result_src_d = 2'b01; reg_write_d = 1'b1; end
      MEMWRITE: begin adr_src_d = 1'b1; mem_write_d = 1'b1; end
      EXECR:    begin alu_src_a_d = 2'b10; alu_op_d = 2'b10; end
      EXECI:    begin alu_src_a_d = 2'b10; alu_src_b_d = 2'b01; alu_op_d = 2'b10; end
      LUI:      begin alu_src_a_d = 2'b11; alu_src_b_d = 2'b01; end
      AUIPC:    begin alu_src_a_d = 2'b01; alu_src_b_d = 2'b01; end
      ALUWB:    reg_write_d = 1'b1;
      BRANCH:   begin alu_src_a_d = 2'b10; alu_op_d = 2'b01; branch_d = 1'b1; end
      JALR:     begin alu_src_a_d = 2'b10; alu_src_b_d = 2'b01; end
      JAL:      begin alu_src_a_d = 2'b01; alu_src_b_d = 2'b10; jal_pc_d = 1'b1; end
      default:  ;
    endcase
  end

  // An instruction retires when its last state hands control back to FETCH.
  // The unknown-opcode path (DECODE -> FETCH) is deliberately excluded.
  assign retire    = (state_d == FETCH) &&
                     ((state_q == MEMWB) || (state_q == MEMWRITE) ||
                      (state_q == ALUWB) || (state_q == BRANCH));
  assign instret_d = instret_q + INSTRET_W'(retire);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      adr_src_q    <= 1'b0;
      alu_src_a_q  <= 2'b00;
      alu_src_b_q  <= 2'b10;
      result_src_q <= 2'b10;
      alu_op_q     <= 2'b00;
      jal_pc_q     <= 1'b0;
      branch_q     <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      instret_q    <= '0;
    end else begin
      state_q      <= state_d;
      adr_src_q    <= adr_src_d;
      alu_src_a_q  <= alu_src_a_d;
      alu_src_b_q  <= alu_src_b_d;
      result_src_q <= result_src_d;
      alu_op_q     <= alu_op_d;
      jal_pc_q     <= jal_pc_d;
      branch_q     <= branch_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      instret_q    <= instret_d;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign illegal_d = (state_d == TRAP);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end
  assign bus.illegal_instr = illegal_q;
`else
  assign bus.illegal_instr = 1'b0;
`endif

  // The FETCH strobes follow mem_ready combinationally; rst masks them so no
  // write can slip out while reset is held.
  assign fetch_strobe   = (state_q == FETCH) && bus.mem_ready && !rst;

  assign bus.adr_src    = adr_src_q;
  assign bus.alu_src_a  = alu_src_a_q;
  assign bus.alu_src_b  = alu_src_b_q;
  assign bus.result_src = result_src_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.ir_write   = fetch_strobe;
  assign bus.pc_update  = fetch_strobe | jal_pc_q;
  assign bus.branch     = branch_q;
  assign bus.reg_write  = reg_write_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.instret    = instret_q;

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Main control state machine for the multicycle RV32I core. It produces the 2-bit select lines for the datapath's 4:1 muxes (ALU source A, ALU source B, result) and the per-cycle write strobes. It sits upstream of the datapath muxes and the ALU decoder. It sequences each instruction through fetch, decode, execute, memory and writeback. It stalls on a memory ready handshake and counts retired instructions.

Parameters:
INSTRET_W, 32, width of retired-instruction counter
RESET_STATE_FETCH, 1, reserved; must stay 1 (reset state is FETCH)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  7  instr[6:0] from instruction register; stable from DECODE until next FETCH
mem_ready  in  1  memory completed current access this cycle
adr_src  out  1  0=PC, 1=ALUOut as memory address
alu_src_a  out  2  00=PC, 01=OldPC, 10=RD1, 11=zero
alu_src_b  out  2  00=RD2, 01=ImmExt, 10=const 4, 11=unused
result_src  out  2  00=ALUOut, 01=read data, 10=ALUResult, 11=unused
alu_op  out  2  00=add, 01=subtract/compare, 10=funct-decoded
ir_write  out  1  latch instruction + OldPC
pc_update  out  1  unconditional PC write
branch  out  1  conditional PC write (datapath ANDs with zero/cond)
reg_write  out  1  register file write
mem_write  out  1  data memory write request
instret  out  INSTRET_W  retired-instruction count
illegal_instr  out  1  sticky illegal-opcode flag

Behaviour:
- Moore FSM; outputs decode from state only. Exception: ir_write and pc_update in FETCH are ANDed with mem_ready.
- Any output not listed for a state is 0. Selects not listed for a state are 00.
- Reset (async, rst=1): state=FETCH, instret=0, illegal_instr=0. While rst=1, all strobes (ir_write, pc_update, branch, reg_write, mem_write) are forced 0. Selects show FETCH values. Reset mid-instruction abandons it; no strobe fires after rst rises.
- FETCH: adr_src=0, a=00, b=10, op=00, result_src=10, ir_write=pc_update=mem_ready. Goes to DECODE when mem_ready=1, else holds.
- DECODE: a=01, b=01, op=00 (branch/JAL target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - other -> see Optional Feature
- MEMADR: a=10, b=01, op=00. Goes to MEMREAD if opcode=0000011, else MEMWRITE.
- MEMREAD: adr_src=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1. Goes to FETCH.
- MEMWRITE: adr_src=1, mem_write=1 held until mem_ready=1, then goes to FETCH. mem_write deasserts on the cycle after acceptance.
- EXECR: a=10, b=00, op=10. Goes to ALUWB.
- EXECI: a=10, b=01, op=10. Goes to ALUWB.
- LUI: a=11, b=01, op=00. Goes to ALUWB.
- AUIPC: a=01, b=01, op=00. Goes to ALUWB.
- ALUWB: result_src=00, reg_write=1. Goes to FETCH.
- BRANCH: a=10, b=00, op=01, result_src=00, branch=1. Goes to FETCH.
- JALR: a=10, b=01, op=00 (target into ALUOut). Goes to JAL.
- JAL: a=01, b=10, op=00, result_src=00, pc_update=1. Goes to ALUWB (writes OldPC+4).
- Latency, no stalls: R/I/LUI/AUIPC 4 cycles; lw 5; sw 4; branch 3; jal 4; jalr 5. Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- instret increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH. It wraps modulo 2^INSTRET_W. It does not increment on the illegal path.
- State register is one-hot or binary at implementer's choice. Unreachable encodings recover to FETCH on the next clock.

Optional Feature:
Macro: CTRL_ILLEGAL_TRAP_EN
- Defined: an unknown opcode in DECODE goes to TRAP. TRAP keeps all strobes 0 and selects 00, asserts illegal_instr=1, and holds until rst.
- Undefined: an unknown opcode in DECODE goes to FETCH (executes as a nop, not counted). illegal_instr is tied 0 and the TRAP state does not exist.

Test Plan:
- Reset: rst pulse mid-EXECR with mem_ready=1. Required: strobes go 0 immediately; after release the state is FETCH, instret=0 and the first cycle shows ir_write=1 and a=00, b=10.
- R-type: opcode=0110011, mem_ready=1. Required: FETCH, DECODE, EXECR, ALUWB; reg_write=1 only in cycle 4 with result_src=00; instret 0 -> 1.
- Load with stall: opcode=0000011, mem_ready=0 for 2 cycles in MEMREAD. Required: 7 cycles total; adr_src=1 throughout MEMREAD; MEMWB has result_src=01 and reg_write=1.
- Store with stall: opcode=0100011, mem_ready=0 for 3 cycles in MEMWRITE. Required: mem_write=1 for exactly 4 cycles and reg_write never asserts.
- JALR: opcode=1100111. Required: JALR with a=10, b=01; then JAL with pc_update=1; then ALUWB with reg_write=1; 5 cycles; instret +1.
- Illegal opcode 0000000. With CTRL_ILLEGAL_TRAP_EN: illegal_instr=1 from the cycle after DECODE and stays 1 for 10 cycles, with no strobes. Without the macro: the state returns to FETCH and instret is unchanged.
